// File: rtl/fuzz_round_ctrl_pkg.sv
// Shared types and default limits for the fuzz-round sequencer.
// Holds the FSM state encoding and the default parameter values.
package fuzz_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_RUN    = 3'd1,
        ST_REPORT = 3'd2,
        ST_RELOAD = 3'd3,
        ST_HALT   = 3'd4
    } fuzz_state_e;

    localparam int unsigned DEF_COV_W       = 30;
    localparam int unsigned DEF_STALL_LIMIT = 1000;
    localparam int unsigned DEF_WDOG_LIMIT  = 50000;
    localparam int unsigned DEF_RST_CYCLES  = 4;
    localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/fuzz_round_ctrl_stall_monitor.sv
// Stall and watchdog counters for the RUN phase, plus the registered interrupt.
// Both counters are held at zero outside RUN and cleared on the round-ending edge.
module fuzz_stall_monitor
    import fuzz_ctrl_pkg::*;
#(
    parameter int unsigned COV_W       = DEF_COV_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int unsigned WDOG_LIMIT  = DEF_WDOG_LIMIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             leave,
    input  logic [COV_W-1:0] cov,
    output logic             irq
);

    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] WDOG_MAX  = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [COV_W-1:0] prev_cov_r;
    logic [CNT_W-1:0] stall_r;
    logic [CNT_W-1:0] wdog_r;
    logic             irq_r;
    logic             stall_hit_s;
    logic             wdog_hit_s;

    assign stall_hit_s = (stall_r >= STALL_MAX);
    assign wdog_hit_s  = (wdog_r >= WDOG_MAX);

    // Previous-cycle coverage, a pure data delay used for change detection.
    always_ff @(posedge clock) begin
        prev_cov_r <= cov;
    end

    // Saturating stall and watchdog counters, live only while in RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_r <= CNT_ZERO;
            wdog_r  <= CNT_ZERO;
        end else if (!run || leave) begin
            stall_r <= CNT_ZERO;
            wdog_r  <= CNT_ZERO;
        end else begin
            if (cov != prev_cov_r) begin
                stall_r <= CNT_ZERO;
            end else if (!stall_hit_s) begin
                stall_r <= stall_r + CNT_ONE;
            end else begin
                stall_r <= stall_r;
            end
            if (!wdog_hit_s) begin
                wdog_r <= wdog_r + CNT_ONE;
            end else begin
                wdog_r <= wdog_r;
            end
        end
    end

    // Interrupt lags the counters by one edge; a passing round suppresses it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= run && !leave && (stall_hit_s || wdog_hit_s);
        end
    end

    assign irq = irq_r;

endmodule

// File: rtl/fuzz_round_ctrl.sv
// Clocked fuzz-round sequencer: DUT reset, run, coverage report and reload
// handshakes, with a stall/watchdog interrupt raised during RUN.
module fuzz_round_ctrl
    import fuzz_ctrl_pkg::*;
#(
    parameter int unsigned COV_W       = DEF_COV_W,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int unsigned WDOG_LIMIT  = DEF_WDOG_LIMIT,
    parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [63:0]      tohost,
    input  logic [COV_W-1:0] cov,
    input  logic             fuzz_en,
    output logic             irq,
    output logic             core_reset,
    output logic             cov_valid,
    output logic [COV_W-1:0] cov_snapshot,
    input  logic             cov_ready,
    input  logic             cov_continue,
    output logic             reload_req,
    input  logic             reload_ack,
    output logic [CNT_W-1:0] round_cnt,
    output logic             halted
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    fuzz_state_e      state_r;
    fuzz_state_e      state_next_s;
    logic [CNT_W-1:0] rst_cnt_r;
    logic [CNT_W-1:0] rst_cnt_next_s;
    logic             capture_s;
    logic             run_s;
    logic             core_reset_r;
    logic             cov_valid_r;
    logic             reload_req_r;
    logic             halted_r;
    logic [COV_W-1:0] cov_snapshot_r;
    logic [CNT_W-1:0] round_cnt_r;
    logic             tohost_unused_s;

    // Only the pass bit of tohost drives the sequencer.
    assign tohost_unused_s = ^tohost[63:1];

    assign run_s = (state_r == ST_RUN);

    fuzz_stall_monitor #(
        .COV_W       (COV_W),
        .CNT_W       (CNT_W),
        .STALL_LIMIT (STALL_LIMIT),
        .WDOG_LIMIT  (WDOG_LIMIT)
    ) u_monitor (
        .clock (clock),
        .reset (reset),
        .run   (run_s),
        .leave (capture_s),
        .cov   (cov),
        .irq   (irq)
    );

    // Next-state logic; handshakes complete in the cycle ready/ack is seen.
    always_comb begin
        state_next_s   = state_r;
        rst_cnt_next_s = rst_cnt_r;
        capture_s      = 1'b0;
        case (state_r)
            ST_RESET: begin
                if (rst_cnt_r >= RST_LAST) begin
                    state_next_s   = ST_RUN;
                    rst_cnt_next_s = CNT_ZERO;
                end else begin
                    rst_cnt_next_s = rst_cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (tohost[0]) begin
                    state_next_s = ST_REPORT;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_REPORT: begin
                if (cov_ready) begin
                    if (cov_continue && fuzz_en) begin
                        state_next_s = ST_RELOAD;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end else begin
                    state_next_s = ST_REPORT;
                end
            end
            ST_RELOAD: begin
                if (reload_ack) begin
                    state_next_s   = ST_RESET;
                    rst_cnt_next_s = CNT_ZERO;
                end else begin
                    state_next_s = ST_RELOAD;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s   = ST_RESET;
                rst_cnt_next_s = CNT_ZERO;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= ST_RESET;
            rst_cnt_r      <= CNT_ZERO;
            core_reset_r   <= 1'b1;
            cov_valid_r    <= 1'b0;
            reload_req_r   <= 1'b0;
            halted_r       <= 1'b0;
            cov_snapshot_r <= {COV_W{1'b0}};
            round_cnt_r    <= CNT_ZERO;
        end else begin
            state_r      <= state_next_s;
            rst_cnt_r    <= rst_cnt_next_s;
            core_reset_r <= (state_next_s != ST_RUN);
            cov_valid_r  <= (state_next_s == ST_REPORT);
            reload_req_r <= (state_next_s == ST_RELOAD);
            halted_r     <= (state_next_s == ST_HALT);
            if (capture_s) begin
                cov_snapshot_r <= cov;
                round_cnt_r    <= round_cnt_r + CNT_ONE;
            end else begin
                cov_snapshot_r <= cov_snapshot_r;
                round_cnt_r    <= round_cnt_r;
            end
        end
    end

    assign core_reset   = core_reset_r;
    assign cov_valid    = cov_valid_r;
    assign reload_req   = reload_req_r;
    assign halted       = halted_r;
    assign cov_snapshot = cov_snapshot_r;
    assign round_cnt    = round_cnt_r;

endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// Self-checking bench for fuzz_round_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural round model.
module tb_fuzz_round_ctrl;

    localparam int COV_W = 30;
    localparam int CNT_W = 32;
    localparam int SL    = 8;
    localparam int WL    = 16;
    localparam int RSTC  = 4;

    localparam int P_RST  = 0;
    localparam int P_RUN  = 1;
    localparam int P_REP  = 2;
    localparam int P_RLD  = 3;
    localparam int P_HALT = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [63:0]      tohost;
    logic [COV_W-1:0] cov;
    logic             fuzz_en;
    logic             cov_ready;
    logic             cov_continue;
    logic             reload_ack;
    wire              irq;
    wire              core_reset;
    wire              cov_valid;
    wire [COV_W-1:0]  cov_snapshot;
    wire              reload_req;
    wire [CNT_W-1:0]  round_cnt;
    wire              halted;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    int               m_phase = P_RST;
    int               m_rleft = RSTC;
    int               m_stall = 0;
    int               m_wdog  = 0;
    logic             m_irq   = 1'b0;
    logic [COV_W-1:0] m_snap  = '0;
    logic [COV_W-1:0] m_prev  = '0;
    logic [CNT_W-1:0] m_rounds = '0;
    logic [COV_W+CNT_W+4:0] exp_o;
    wire  [COV_W+CNT_W+4:0] obs = {irq, core_reset, cov_valid, reload_req, halted,
                                   cov_snapshot, round_cnt};

    always #5 clock = ~clock;

    fuzz_round_ctrl #(
        .COV_W       (COV_W),
        .STALL_LIMIT (SL),
        .WDOG_LIMIT  (WL),
        .RST_CYCLES  (RSTC),
        .CNT_W       (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tohost       (tohost),
        .cov          (cov),
        .fuzz_en      (fuzz_en),
        .irq          (irq),
        .core_reset   (core_reset),
        .cov_valid    (cov_valid),
        .cov_snapshot (cov_snapshot),
        .cov_ready    (cov_ready),
        .cov_continue (cov_continue),
        .reload_req   (reload_req),
        .reload_ack   (reload_ack),
        .round_cnt    (round_cnt),
        .halted       (halted)
    );

    task automatic model_step();
        logic nirq;
        if (!reset) begin
            m_phase  = P_RST;
            m_rleft  = RSTC;
            m_stall  = 0;
            m_wdog   = 0;
            m_irq    = 1'b0;
            m_snap   = '0;
            m_rounds = '0;
        end else begin
            nirq = (m_phase == P_RUN) && !tohost[0] && (m_stall >= SL || m_wdog >= WL);
            case (m_phase)
                P_RST: begin
                    m_rleft = m_rleft - 1;
                    if (m_rleft == 0) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (tohost[0]) begin
                        m_snap   = cov;
                        m_rounds = m_rounds + 32'd1;
                        m_phase  = P_REP;
                        m_stall  = 0;
                        m_wdog   = 0;
                    end else begin
                        m_stall = (cov != m_prev) ? 0 : ((m_stall < SL) ? m_stall + 1 : SL);
                        m_wdog  = (m_wdog < WL) ? m_wdog + 1 : WL;
                    end
                end
                P_REP: if (cov_ready) m_phase = (cov_continue && fuzz_en) ? P_RLD : P_HALT;
                P_RLD: if (reload_ack) begin
                    m_phase = P_RST;
                    m_rleft = RSTC;
                end
                default: ;
            endcase
            m_irq = nirq;
        end
        m_prev = cov;
        exp_o = {m_irq, m_phase != P_RUN, m_phase == P_REP, m_phase == P_RLD,
                 m_phase == P_HALT, m_snap, m_rounds};
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        tohost       = 64'd0;
        cov_ready    = 1'b0;
        cov_continue = 1'b0;
        fuzz_en      = 1'b1;
        reload_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        cov   = 30'd0;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) reset = 1'b1;
            tick();
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_round_reload();
        for (int i = 0; i < 40; i++) begin
            cov          = 30'd5;
            tohost       = (i == 19) ? 64'd1 : 64'd0;
            cov_ready    = (i == 23);
            cov_continue = 1'b1;
            fuzz_en      = 1'b1;
            reload_ack   = (i == 26);
            tick();
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL round_reload cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_stall();
        cov = 30'd7;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cov = (i < 16) ? 30'd7 : 30'd9;
            tick();
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cov    = 30'(i + 100);
            tohost = (i == 25) ? 64'd1 : 64'd0;
            tick();
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL watchdog cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_pass_vs_limit();
        bit hit = 1'b0;
        cov = 30'd3;
        do_reset();
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_phase == P_RUN && m_stall == SL - 1) begin
                hit    = 1'b1;
                tohost = 64'd1;
            end
            tick();
            tohost = 64'd0;
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL pass_vs_limit cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
        vectors++;
        if (!hit || irq !== 1'b0 || cov_valid !== 1'b1) begin
            $display("FAIL pass_vs_limit_edge hit=%0b irq=%b cov_valid=%b required irq=0 cov_valid=1",
                     hit, irq, cov_valid);
            miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL pass_vs_limit_after cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_halt();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            for (int i = 0; i < 24; i++) begin
                cov          = 30'(v * 50 + i);
                tohost       = (i == 6 || i >= 12) ? 64'd1 : 64'd0;
                fuzz_en      = (v == 1);
                cov_continue = (v == 0);
                cov_ready    = (i == 8 || i >= 12);
                reload_ack   = (i >= 12);
                tick();
                vectors++;
                if (obs !== exp_o) begin
                    $display("FAIL halt v=%0d cyc=%0d got=%h exp=%h", v, i, obs, exp_o);
                    miscompares++;
                end
            end
            vectors++;
            if (halted !== 1'b1 || core_reset !== 1'b1 || round_cnt !== 32'd1) begin
                $display("FAIL halt_final v=%0d halted=%b core_reset=%b round_cnt=%0d required 1 1 1",
                         v, halted, core_reset, round_cnt);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) != 0);
            tohost       = {$urandom, $urandom};
            tohost[0]    = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) == 0) cov = 30'($urandom_range(0, 3));
            fuzz_en      = ($urandom_range(0, 7) != 0);
            cov_ready    = 1'($urandom_range(0, 1));
            cov_continue = ($urandom_range(0, 7) != 0);
            reload_ack   = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (obs !== exp_o) begin
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_o);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_reload();
        test_stall();
        test_watchdog();
        test_pass_vs_limit();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
